// File: rtl/mem_ctrl_if.sv
// Request/response bus between the MEM stage (master) and mem_ctrl (slave).
interface mem_ctrl_if;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_signed;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_signed,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_signed,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: byte/half/word accesses become single-byte RAM cycles.
// Define MEM_CTRL_ALIGN_CHECK_EN to reject misaligned half/word accesses with resp_err.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  mem_ctrl_if.slave   bus,
  output logic [31:0] ram_a,
  output logic [7:0]  ram_dout,
  output logic        ram_wr,
  input  logic [7:0]  ram_din
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state, state_nx;
  logic [2:0]  cnt, cnt_nx, nbytes;
  logic [31:0] addr, wdata, load_data, load_nx, rdata_q, rdata_nx;
  logic [1:0]  size, cap_idx;
  logic        sgn, accept, bad_align;

  assign accept  = (state == IDLE) && bus.req_valid && rdy;
  assign cap_idx = cnt[1:0] - 2'd1;

`ifdef MEM_CTRL_ALIGN_CHECK_EN
  logic err_q;
  assign bad_align = (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                     (bus.req_size[1] && bus.req_addr[1:0] != 2'b00);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         err_q <= 1'b0;
    else if (accept) err_q <= bad_align;
  end
  assign bus.resp_err = (state == DONE) && rdy && err_q;
`else
  assign bad_align    = 1'b0;
  assign bus.resp_err = 1'b0;
`endif

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == DONE) && rdy;
  assign bus.resp_rdata = rdata_q;

  function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] sz, input logic s);
    case (sz)
      2'b00:   extend = {{24{s & d[7]}}, d[7:0]};
      2'b01:   extend = {{16{s & d[15]}}, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  always_comb begin
    case (size)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    load_nx  = load_data;
    rdata_nx = rdata_q;
    ram_a    = '0;
    ram_dout = '0;
    ram_wr   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_nx  = 3'd0;
          load_nx = '0;
          if (bad_align) begin
            state_nx = DONE;
            rdata_nx = '0;
          end else if (bus.req_we) begin
            state_nx = WRITE;
          end else begin
            state_nx = READ;
          end
        end
      end
      WRITE: begin
        ram_a    = addr + {29'd0, cnt};
        ram_dout = wdata[{cnt[1:0], 3'b000} +: 8];
        if (rdy) begin
          ram_wr = 1'b1;
          cnt_nx = cnt + 3'd1;
          if (cnt == nbytes - 3'd1) begin
            state_nx = DONE;
            rdata_nx = '0;
          end
        end
      end
      READ: begin
        // While stalled (or on the final capture cycle) keep the previous address so ram_din stays valid.
        if (cnt != 3'd0 && (!rdy || cnt == nbytes)) ram_a = addr + {29'd0, cnt} - 32'd1;
        else                                         ram_a = addr + {29'd0, cnt};
        if (rdy) begin
          if (cnt != 3'd0) load_nx[{cap_idx, 3'b000} +: 8] = ram_din;
          cnt_nx = cnt + 3'd1;
          if (cnt == nbytes) begin
            state_nx = DONE;
            rdata_nx = extend(load_nx, size, sgn);
          end
        end
      end
      DONE: begin
        if (rdy) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      addr      <= '0;
      wdata     <= '0;
      size      <= 2'b00;
      sgn       <= 1'b0;
      load_data <= '0;
      rdata_q   <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      load_data <= load_nx;
      rdata_q   <= rdata_nx;
      if (accept) begin
        addr  <= bus.req_addr;
        wdata <= bus.req_wdata;
        size  <= bus.req_size;
        sgn   <= bus.req_signed;
      end
    end
  end
endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 rdy  in  1  global ready; 0 freezes the block.
REQ-004 req_valid  in  1  MEM-stage access request.
REQ-005 req_we  in  1  1 = store, 0 = load.
REQ-006 req_addr  in  32  byte address.
REQ-007 req_wdata  in  32  store data; byte k = bits [8k+7:8k].
REQ-008 req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-009 req_signed  in  1  1 = sign-extend load result, 0 = zero-extend.
REQ-010 req_ready  out  1  request accepted at edge when req_valid && req_ready && rdy.
REQ-011 resp_valid  out  1  one-cycle completion pulse (loads and stores).
REQ-012 resp_rdata  out  32  extended load data; 0 for stores.
REQ-013 resp_err  out  1  misalignment flag (see Configuration).
REQ-014 ram_a  out  32  RAM byte address.
REQ-015 ram_dout  out  8  RAM write byte.
REQ-016 ram_wr  out  1  RAM write strobe.
REQ-017 ram_din  in  8  RAM read byte; valid the cycle after ram_a presented with ram_wr=0.

Function
REQ-018 The FSM SHALL have states IDLE, READ, WRITE, DONE; req_ready=1 only in IDLE.
REQ-019 On acceptance, addr/wdata/size/signed/we SHALL be latched, byte counter cnt=0, next state WRITE (store) or READ (load); nbytes = 1/2/4 by size.
REQ-020 WRITE: each active cycle ram_a=addr+cnt (mod 2^32), ram_dout=byte cnt, ram_wr=1, cnt++; after byte nbytes-1 go DONE.
REQ-021 READ: active cycle k (k=0..nbytes) presents ram_a=addr+k for k<nbytes and captures ram_din into byte k-1 for k>=1; after capture of byte nbytes-1 go DONE.
REQ-022 DONE: resp_valid=1 for exactly one cycle, then IDLE; resp_rdata holds value until next DONE.
REQ-023 Latency from acceptance edge: store resp_valid in cycle nbytes+1, load in cycle nbytes+2 (byte store 2, word load 6).
REQ-024 Load extension: bytes above size filled with sign bit of top loaded byte if req_signed, else zero.
REQ-025 ram_wr SHALL be 0 in every state except WRITE with rdy=1.
REQ-026 rdy=0: state, cnt, captured data frozen, no capture, ram_wr=0; in READ with cnt>=1 ram_a SHALL present addr+cnt-1 so ram_din is valid on resumption.
REQ-027 req_valid outside IDLE SHALL be ignored; requester holds request until accepted.
REQ-028 Address increment SHALL wrap 0xFFFFFFFF -> 0x00000000.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, cnt=0, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, ram_a=0, ram_dout=0, ram_wr=0.
REQ-030 Reset mid-operation SHALL abort the access; no further ram_wr and no resp_valid for it.

Configuration
REQ-031 With MEM_CTRL_ALIGN_CHECK_EN defined, a half at odd address or word at address not multiple of 4 SHALL perform no RAM access, go directly to DONE, and assert resp_err=1 with resp_valid, resp_rdata=0.
REQ-032 Without MEM_CTRL_ALIGN_CHECK_EN, resp_err SHALL be constant 0 and misaligned accesses SHALL complete byte-serially per REQ-020/021.

Verification
REQ-033 Store word 0x11223344 to 0x100 -> ram_wr cycles write 0x44,0x33,0x22,0x11 to 0x100..0x103; resp_valid cycle 5.
REQ-034 Load signed byte from address holding 0x80 -> resp_rdata=0xFFFFFF80, resp_valid cycle 3; unsigned -> 0x00000080.
REQ-035 Load half at 0xFFFFFFFF (check macro off) -> ram_a 0xFFFFFFFF then 0x00000000; bytes assembled correctly.
REQ-036 Word load with rdy=0 for 3 cycles after byte 1 -> same result as unstalled, latency +3, no ram_wr.
REQ-037 Assert rst during WRITE after byte 1 -> ram_wr=0 immediately, no resp_valid, req_ready=1 after reset.
REQ-038 Macro on: word load at 0x102 -> resp_valid+resp_err=1 in cycle 1, no ram_a change, resp_rdata=0.
